// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: load-use interlock against the load in EX and a
// single outstanding multi-cycle mul/div tracked by a two-state FSM.
`ifndef REG_LOG
`define REG_LOG 5
`endif

module hazard_scoreboard #(
  parameter int REG_LOG = `REG_LOG,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 flush,
  input  logic [REG_LOG*3-1:0] rs_ID,
  input  logic [2:0]           rs_used_ID,
  input  logic [REG_LOG-1:0]   rd_ID,
  input  logic                 REG_write_ID,
  input  logic                 ld_ID,
  input  logic                 md_ID,
  input  logic                 md_done,
  output logic                 stall,
  output logic [1:0]           stall_cause,
  output logic                 md_busy,
  output logic [CNT_W-1:0]     stall_cycles
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t            state_r, state_next_s;
  logic [REG_LOG-1:0]   md_rd_r, md_rd_next_s;
  logic                 ld_v_ex_r, ld_v_ex_next_s;
  logic [REG_LOG-1:0]   ld_rd_ex_r, ld_rd_ex_next_s;
  logic [CNT_W-1:0]     stall_cycles_r;

  logic                 issue_s;
  logic                 ld_use_s;
  logic                 md_raw_s;
  logic                 md_struct_s;
  logic                 stall_s;
  logic [1:0]           cause_s;

  // Register 0 never matches, so it can never create a dependency.
  function automatic logic src_match(input logic [REG_LOG*3-1:0] rs,
                                     input logic [2:0]           used,
                                     input logic [REG_LOG-1:0]   x);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit = hit | (used[i] & (rs[REG_LOG*(3-i)-1 -: REG_LOG] == x) & (|x));
    end
    return hit;
  endfunction

  // Hazard detection, stall decision and cause encoding.
  always_comb begin
    ld_use_s    = ld_v_ex_r & src_match(rs_ID, rs_used_ID, ld_rd_ex_r);
    md_raw_s    = 1'b0;
    md_struct_s = 1'b0;
    if (state_r == MD_BUSY) begin
      md_raw_s    = src_match(rs_ID, rs_used_ID, md_rd_r)
                  | (REG_write_ID & (|md_rd_r) & (rd_ID == md_rd_r));
      md_struct_s = md_ID;
    end else begin
      md_raw_s    = 1'b0;
      md_struct_s = 1'b0;
    end
    stall_s = id_valid & ~flush & (ld_use_s | md_raw_s | md_struct_s);
    issue_s = id_valid & ~flush & ~stall_s;
    if (!stall_s) begin
      cause_s = 2'b00;
    end else if (ld_use_s) begin
      cause_s = 2'b01;
    end else if (md_raw_s) begin
      cause_s = 2'b10;
    end else begin
      cause_s = 2'b11;
    end
  end

  // Mul/div FSM next state; md_done is only meaningful while busy.
  always_comb begin
    state_next_s = state_r;
    md_rd_next_s = md_rd_r;
    case (state_r)
      IDLE: begin
        if (issue_s && md_ID) begin
          state_next_s = MD_BUSY;
          md_rd_next_s = REG_write_ID ? rd_ID : {REG_LOG{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      MD_BUSY: begin
        if (md_done) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = MD_BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
        md_rd_next_s = {REG_LOG{1'b0}};
      end
    endcase
  end

  // Load-in-EX tracking: any cycle without a qualifying load issue is a bubble.
  always_comb begin
    ld_rd_ex_next_s = ld_rd_ex_r;
    if (issue_s && ld_ID && REG_write_ID && (|rd_ID)) begin
      ld_v_ex_next_s  = 1'b1;
      ld_rd_ex_next_s = rd_ID;
    end else begin
      ld_v_ex_next_s  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Tracked destinations and the wrapping stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_rd_r        <= {REG_LOG{1'b0}};
      ld_v_ex_r      <= 1'b0;
      ld_rd_ex_r     <= {REG_LOG{1'b0}};
      stall_cycles_r <= {CNT_W{1'b0}};
    end else begin
      md_rd_r        <= md_rd_next_s;
      ld_v_ex_r      <= ld_v_ex_next_s;
      ld_rd_ex_r     <= ld_rd_ex_next_s;
      stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, stall_s};
    end
  end

  assign stall        = stall_s;
  assign stall_cause  = cause_s;
  assign md_busy      = (state_r == MD_BUSY);
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, corner
// sequences and random stimulus against a register-dependency reference model.
module tb_hazard_scoreboard;
  localparam int RL = 5;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, flush;
  logic [RL*3-1:0] rs_ID;
  logic [2:0]      rs_used_ID;
  logic [RL-1:0]   rd_ID;
  logic            REG_write_ID, ld_ID, md_ID, md_done;
  logic            stall;
  logic [1:0]      stall_cause;
  logic            md_busy;
  logic [CW-1:0]   stall_cycles;

  int errors = 0;
  int checks = 0;

  // Reference model: pending load destination, outstanding mul/div destination.
  bit m_ld_v;
  int m_ld_rd;
  bit m_busy;
  int m_md_rd;
  int m_cnt;

  typedef struct {
    logic       v, fl;
    logic [4:0] a0, a1, a2;
    logic [2:0] used;
    logic [4:0] rd;
    logic       wr, ld, md, done;
    logic       exp_st;
    logic [1:0] exp_c;
  } vec_t;

  vec_t tab[22];

  hazard_scoreboard #(.REG_LOG(RL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
    .rs_ID(rs_ID), .rs_used_ID(rs_used_ID), .rd_ID(rd_ID),
    .REG_write_ID(REG_write_ID), .ld_ID(ld_ID), .md_ID(md_ID),
    .md_done(md_done), .stall(stall), .stall_cause(stall_cause),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit v, input bit fl, input int a0, input int a1,
                              input int a2, input bit [2:0] used, input int rd,
                              input bit wr, input bit ld, input bit md, input bit done,
                              input bit st, input int c);
    vec_t t;
    t.v = v; t.fl = fl; t.a0 = 5'(a0); t.a1 = 5'(a1); t.a2 = 5'(a2);
    t.used = used; t.rd = 5'(rd); t.wr = wr; t.ld = ld; t.md = md;
    t.done = done; t.exp_st = st; t.exp_c = 2'(c);
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit reads(input vec_t t, input int x);
    if (x == 0) return 1'b0;
    return (t.used[0] && int'(t.a0) == x) || (t.used[1] && int'(t.a1) == x) ||
           (t.used[2] && int'(t.a2) == x);
  endfunction

  task automatic idle();
    id_valid = 1'b0; flush = 1'b0; rs_ID = '0; rs_used_ID = 3'b000; rd_ID = '0;
    REG_write_ID = 1'b0; ld_ID = 1'b0; md_ID = 1'b0; md_done = 1'b0;
  endtask

  task automatic model_reset();
    m_ld_v = 1'b0; m_ld_rd = 0; m_busy = 1'b0; m_md_rd = 0; m_cnt = 0;
  endtask

  // One ID-stage cycle: drive on negedge, check before the next rising edge.
  task automatic cyc(input vec_t t, input bit tab_chk, input string nm);
    bit lu, raw, st, exp_st, iss;
    int exp_c;
    @(negedge clk);
    id_valid = t.v; flush = t.fl; rs_ID = {t.a0, t.a1, t.a2}; rs_used_ID = t.used;
    rd_ID = t.rd; REG_write_ID = t.wr; ld_ID = t.ld; md_ID = t.md; md_done = t.done;
    #1;
    lu  = m_ld_v && reads(t, m_ld_rd);
    raw = m_busy && (reads(t, m_md_rd) || (t.wr && m_md_rd != 0 && int'(t.rd) == m_md_rd));
    st  = m_busy && t.md;
    exp_st = t.v && !t.fl && (lu || raw || st);
    exp_c  = !exp_st ? 0 : lu ? 1 : raw ? 2 : 3;
    check({nm, ".stall"}, 32'(stall), 32'(exp_st));
    check({nm, ".cause"}, 32'(stall_cause), 32'(exp_c));
    check({nm, ".md_busy"}, 32'(md_busy), 32'(m_busy));
    check({nm, ".stall_cycles"}, 32'(stall_cycles), 32'(m_cnt));
    if (tab_chk) begin
      check({nm, ".tab_stall"}, 32'(stall), 32'(t.exp_st));
      check({nm, ".tab_cause"}, 32'(stall_cause), 32'(t.exp_c));
    end
    iss = t.v && !t.fl && !exp_st;
    m_ld_v = iss && t.ld && t.wr && t.rd != 0;
    if (m_ld_v) m_ld_rd = int'(t.rd);
    if (!m_busy) begin
      if (iss && t.md) begin
        m_busy  = 1'b1;
        m_md_rd = t.wr ? int'(t.rd) : 0;
      end
    end else if (t.done) begin
      m_busy = 1'b0;
    end
    m_cnt = (m_cnt + int'(exp_st)) % (1 << CW);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.cause", 32'(stall_cause), 32'd0);
    check("reset.md_busy", 32'(md_busy), 32'd0);
    check("reset.stall_cycles", 32'(stall_cycles), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t r;
    //              v fl a0 a1 a2 used   rd wr ld md dn st c
    tab[0]  = mk(1, 0, 0, 0, 0, 3'b000, 5, 1, 1, 0, 0, 0, 0);
    tab[1]  = mk(1, 0, 0, 5, 0, 3'b010, 0, 0, 0, 0, 0, 1, 1);
    tab[2]  = mk(1, 0, 0, 5, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    tab[3]  = mk(1, 0, 0, 0, 0, 3'b000, 7, 1, 0, 1, 0, 0, 0);
    tab[4]  = mk(1, 0, 7, 0, 0, 3'b001, 1, 1, 0, 0, 0, 1, 2);
    tab[5]  = mk(1, 0, 7, 0, 0, 3'b001, 1, 1, 0, 0, 0, 1, 2);
    tab[6]  = mk(1, 0, 7, 0, 0, 3'b001, 1, 1, 0, 0, 0, 1, 2);
    tab[7]  = mk(1, 0, 7, 0, 0, 3'b001, 1, 1, 0, 0, 1, 1, 2);
    tab[8]  = mk(1, 0, 7, 0, 0, 3'b001, 1, 1, 0, 0, 0, 0, 0);
    tab[9]  = mk(1, 0, 0, 0, 0, 3'b000, 3, 1, 0, 1, 0, 0, 0);
    tab[10] = mk(1, 0, 1, 2, 0, 3'b011, 3, 1, 0, 0, 0, 1, 2);
    tab[11] = mk(1, 0, 1, 0, 0, 3'b001, 4, 1, 0, 1, 0, 1, 3);
    tab[12] = mk(1, 0, 0, 0, 0, 3'b001, 0, 1, 1, 0, 0, 0, 0);
    tab[13] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0);
    tab[14] = mk(1, 0, 0, 0, 0, 3'b000, 9, 1, 1, 0, 0, 0, 0);
    tab[15] = mk(1, 1, 0, 0, 9, 3'b100, 0, 0, 0, 0, 0, 0, 0);
    tab[16] = mk(1, 0, 0, 0, 9, 3'b100, 0, 0, 0, 0, 0, 0, 0);
    tab[17] = mk(1, 0, 0, 0, 0, 3'b000, 6, 1, 0, 1, 0, 0, 0);
    tab[18] = mk(1, 0, 0, 0, 0, 3'b000, 8, 1, 1, 0, 0, 0, 0);
    tab[19] = mk(1, 0, 8, 6, 0, 3'b011, 0, 0, 0, 1, 0, 1, 1);
    tab[20] = mk(1, 0, 8, 6, 0, 3'b011, 0, 0, 0, 1, 0, 1, 2);
    tab[21] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0);

    rst = 1'b1;
    idle();
    model_reset();
    do_reset();

    for (int i = 0; i < 22; i++) cyc(tab[i], 1'b1, $sformatf("tab%0d", i));

    // Reset in the middle of a mul/div; a later md_done must be ignored.
    do_reset();
    cyc(mk(1, 0, 0, 0, 0, 3'b000, 7, 1, 0, 1, 0, 0, 0), 1'b1, "rstmid.issue");
    @(posedge clk);
    #2;
    check("rstmid.busy_before", 32'(md_busy), 32'd1);
    rst = 1'b1;
    idle();
    #1;
    check("rstmid.busy_async", 32'(md_busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0), 1'b1, "rstmid.done");
    cyc(mk(1, 0, 7, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0), 1'b1, "rstmid.after");

    // Counter wrap: 17 stalled cycles in a 4-bit counter leave 1.
    do_reset();
    cyc(mk(1, 0, 0, 0, 0, 3'b000, 2, 1, 0, 1, 0, 0, 0), 1'b1, "wrap.issue");
    for (int i = 0; i < 17; i++)
      cyc(mk(1, 0, 0, 2, 0, 3'b010, 0, 0, 0, 0, 0, 1, 2), 1'b1, $sformatf("wrap.s%0d", i));
    cyc(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0), 1'b1, "wrap.end");
    check("wrap.count", 32'(stall_cycles), 32'd1);

    // Random traffic over a small register range to provoke collisions.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r.v    = ($urandom_range(0, 3) != 0);
      r.fl   = ($urandom_range(0, 7) == 0);
      r.a0   = 5'($urandom_range(0, 7));
      r.a1   = 5'($urandom_range(0, 7));
      r.a2   = 5'($urandom_range(0, 7));
      r.used = 3'($urandom_range(0, 7));
      r.rd   = 5'($urandom_range(0, 7));
      r.wr   = ($urandom_range(0, 3) != 0);
      r.ld   = ($urandom_range(0, 3) == 0);
      r.md   = ($urandom_range(0, 4) == 0);
      r.done = ($urandom_range(0, 3) == 0);
      r.exp_st = 1'b0;
      r.exp_c  = 2'b00;
      cyc(r, 1'b0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
